// File: rtl/decode_issue.sv
// Decode/issue stage: decodes one instruction into the execute operand bundle,
// holds it while execute works, then retires it. Owns the integer register file.
module decode_issue #(
    parameter logic [31:0] SP_INIT = 32'h0003_FFFC,
    parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        exec_busy,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] pc,
    output logic [5:0]  instr,
    output logic [1:0]  op_type,
    output logic [31:0] s,
    output logic [31:0] t,
    output logic [31:0] imm,
    output logic        branch,
    output logic        jump,
    output logic        is_jr,
    output logic        start,
    output logic        retire,
    output logic        dst_en,
    output logic [4:0]  dst_addr
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_FPU   = 6'b010001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LUI_S = 6'b011111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LW_S  = 6'b110001;
    localparam logic [5:0] OP_IN    = 6'b111110;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        capture;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data;

    logic [1:0]  dec_op_type;
    logic [5:0]  dec_instr;
    logic [31:0] dec_s, dec_imm;
    logic        dec_branch, dec_jump, dec_is_jr, dec_has_dst, dec_dst_en;
    logic [4:0]  dec_dst_addr;

    logic [31:0] pc_q, pc_d, s_q, s_d, t_q, t_d, imm_q, imm_d;
    logic [5:0]  instr_q, instr_d;
    logic [1:0]  op_type_q, op_type_d;
    logic        branch_q, branch_d, jump_q, jump_d, is_jr_q, is_jr_d;
    logic        dst_en_q, dst_en_d;
    logic [4:0]  dst_addr_q, dst_addr_d;

    assign op    = in_instr[31:26];
    assign rs    = in_instr[25:21];
    assign rt    = in_instr[20:16];
    assign rd    = in_instr[15:11];
    assign funct = in_instr[5:0];

    // Same-cycle writeback is forwarded so capture never sees a stale register.
    assign rs_data = (rs == 5'd0) ? 32'd0 :
                     (wb_en && wb_addr == rs) ? wb_data : regs_q[rs];
    assign rt_data = (rt == 5'd0) ? 32'd0 :
                     (wb_en && wb_addr == rt) ? wb_data : regs_q[rt];

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_en && wb_addr != 5'd0) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        dec_op_type  = 2'd0;
        dec_instr    = op;
        dec_is_jr    = 1'b0;
        dec_has_dst  = 1'b0;
        dec_dst_addr = 5'd0;
        dec_s        = rs_data;
        dec_imm      = {{16{in_instr[15]}}, in_instr[15:0]};
        dec_branch   = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ);
        dec_jump     = (op == OP_J) || (op == OP_JAL);

        if (op == OP_RTYPE) begin
            dec_op_type = 2'd1;
            dec_instr   = funct;
            dec_is_jr   = (funct == FN_JR);
        end else if (op == OP_FPU) begin
            dec_op_type = 2'd2;
            dec_instr   = funct;
        end

        case (op)
            OP_ANDI, OP_ORI, OP_XORI: dec_imm = {16'd0, in_instr[15:0]};
            OP_J, OP_JAL:             dec_imm = {6'd0, in_instr[25:0]};
            default:                  ;
        endcase

        // JAL passes its link address to execute through the s operand.
        if (op == OP_JAL) begin
            dec_s = in_pc + 32'd4;
        end

        if ((op == OP_RTYPE && !dec_is_jr) || op == OP_FPU) begin
            dec_has_dst  = 1'b1;
            dec_dst_addr = rd;
        end else begin
            case (op)
                OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI,
                OP_LW, OP_LW_S, OP_LUI_S, OP_IN: begin
                    dec_has_dst  = 1'b1;
                    dec_dst_addr = rt;
                end
                OP_JAL: begin
                    dec_has_dst  = 1'b1;
                    dec_dst_addr = 5'd31;
                end
                default: ;
            endcase
        end
        dec_dst_en = dec_has_dst && (dec_dst_addr != 5'd0);
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        in_ready = 1'b0;
        start    = 1'b0;
        retire   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start   = 1'b1;
                state_d = exec_busy ? BUSY : DONE;
            end
            BUSY: begin
                if (!exec_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                retire  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        op_type_d  = op_type_q;
        s_d        = s_q;
        t_d        = t_q;
        imm_d      = imm_q;
        branch_d   = branch_q;
        jump_d     = jump_q;
        is_jr_d    = is_jr_q;
        dst_en_d   = dst_en_q;
        dst_addr_d = dst_addr_q;
        if (capture) begin
            pc_d       = in_pc;
            instr_d    = dec_instr;
            op_type_d  = dec_op_type;
            s_d        = dec_s;
            t_d        = rt_data;
            imm_d      = dec_imm;
            branch_d   = dec_branch;
            jump_d     = dec_jump;
            is_jr_d    = dec_is_jr;
            dst_en_d   = dec_dst_en;
            dst_addr_d = dec_dst_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= 32'd0;
            instr_q    <= 6'd0;
            op_type_q  <= 2'd0;
            s_q        <= 32'd0;
            t_q        <= 32'd0;
            imm_q      <= 32'd0;
            branch_q   <= 1'b0;
            jump_q     <= 1'b0;
            is_jr_q    <= 1'b0;
            dst_en_q   <= 1'b0;
            dst_addr_q <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 29) ? SP_INIT : ((i == 28) ? GP_INIT : 32'd0);
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            op_type_q  <= op_type_d;
            s_q        <= s_d;
            t_q        <= t_d;
            imm_q      <= imm_d;
            branch_q   <= branch_d;
            jump_q     <= jump_d;
            is_jr_q    <= is_jr_d;
            dst_en_q   <= dst_en_d;
            dst_addr_q <= dst_addr_d;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign pc       = pc_q;
    assign instr    = instr_q;
    assign op_type  = op_type_q;
    assign s        = s_q;
    assign t        = t_q;
    assign imm      = imm_q;
    assign branch   = branch_q;
    assign jump     = jump_q;
    assign is_jr    = is_jr_q;
    assign dst_en   = dst_en_q;
    assign dst_addr = dst_addr_q;

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/issue stage between instruction fetch and the execute stage. Accepts one 32-bit instruction with its PC and decodes it into the execute operand bundle: op class, function code, operands from the register file, immediate and branch/jump flags. It pulses `start`, holds the bundle stable while execute is busy (UART `in`/`out`), then signals retirement with the destination register so writeback can capture execute's `d`/`npc`. Owns the 32×32 integer register file and its write port.

## Interface
- `SP_INIT`, 32'h0003_FFFC — reset value of r29 (stack pointer).
- `GP_INIT`, 32'h0 — reset value of r28.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — fetch presents an instruction.
- `in_ready`  out  1  — decode can accept (high only in IDLE).
- `in_instr`  in  32  — instruction word.
- `in_pc`  in  32  — its address.
- `exec_busy`  in  1  — execute's `uart_state`.
- `wb_en`, `wb_addr`, `wb_data`  in  1/5/32  — register write port.
- `pc`  out  32  — PC of the issued instruction.
- `instr`  out  6  — opcode (class 0) or funct (classes 1, 2).
- `op_type`  out  2  — 0 = I/J, 1 = integer R, 2 = FPU.
- `s`, `t`, `imm`  out  32 each — operands.
- `branch`, `jump`, `is_jr`  out  1 each.
- `start`  out  1  — one-cycle issue pulse.
- `retire`  out  1  — one-cycle pulse: execute result valid this cycle.
- `dst_en`, `dst_addr`  out  1/5  — writeback target, valid with `retire`.

## Operation
- Fields: op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- Class:
  - op = 000000 → `op_type` = 1, `instr` = funct.
  - op = 010001 → `op_type` = 2, `instr` = funct.
  - otherwise → `op_type` = 0, `instr` = op.
- `s` = R[rs], `t` = R[rt]. Exception: JAL (000011) drives `s` = `in_pc` + 4.
- `imm`:
  - ANDI/ORI/XORI: zero-extended [15:0].
  - J/JAL: {6'b0, [25:0]}.
  - All others: sign-extended [15:0].
- Flags:
  - `branch` for op ∈ {BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111}.
  - `jump` for J 000010 and JAL 000011.
  - `is_jr` for `op_type` = 1 with funct 001000.
- Destination:
  - rd for class 1 (except JR) and class 2.
  - rt for ADDI/ANDI/ORI/XORI/SLTI/LUI/LW/LW_S(110001)/LUI_S(011111)/IN(111110).
  - 31 for JAL.
  - Otherwise `dst_en` = 0.
  - `dst_en` is forced 0 when the destination is r0.
- Register file:
  - r0 reads 0; writes to r0 are ignored.
  - Write occurs on the clock edge when `wb_en`.
  - Read bypass: if `wb_en` and `wb_addr` == a read address (≠0) in the capture cycle, `wb_data` is used.
- FSM:
  - IDLE: `in_ready` = 1. On `in_valid`: register decoded bundle → ISSUE.
  - ISSUE: `start` = 1. If `exec_busy` → BUSY, else → DONE.
  - BUSY: stay while `exec_busy`; when low → DONE.
  - DONE: `retire` = 1 → IDLE.
- Bundle outputs are held constant from ISSUE through DONE.
- Only one instruction is in flight, so no hazard logic beyond the bypass.

## Timing
- Reset:
  - State → IDLE.
  - All outputs 0, except `in_ready` = 1 in the cycle after reset.
  - Registers 0, except r29 = `SP_INIT` and r28 = `GP_INIT`.
  - Reset in any state aborts the instruction; no `retire` follows.
- Accept at edge N.
- `start` is high during cycle N+1.
- Non-UART instruction: `retire` in cycle N+2. This is the cycle execute's registered `d` and `npc` are valid.
- UART instruction: execute raises `exec_busy` combinationally in the ISSUE cycle. `retire` comes one cycle after `exec_busy` is first seen low in BUSY.
- Minimum throughput: one instruction per 3 cycles; `in_ready` is low in ISSUE, BUSY and DONE.
- A `wb_en` write in DONE commits at that edge and is visible to the instruction captured in the next IDLE cycle.
- A same-cycle write during capture is forwarded via the bypass.
- `exec_busy` is ignored outside ISSUE and BUSY.

## Test plan
- Reset, then query r29 via ADD r1, r29, r0: `s` = 32'h0003_FFFC; `start` in cycle 1 after accept; `retire` in cycle 2 with `dst_addr` = 1.
- Capture while `wb_en`=1, `wb_addr`=5, `wb_data`=32'h1234, instr ADDI r6, r5, -1: `s` = 32'h1234, `imm` = 32'hFFFF_FFFF, `dst_addr` = 6.
- ORI r2, r0, 16'h8000 → `imm` = 32'h0000_8000. JAL 0x40 at pc 0x100 → `s` = 0x104, `imm` = 0x40, `jump` = 1, `dst_addr` = 31.
- OUT with `exec_busy` held high for 4 cycles after `start`: `in_ready` = 0 throughout, bundle stable, `retire` exactly 1 cycle after `exec_busy` falls.
- BEQ / SW / JR r31 / ADD r0 → `dst_en` = 0; BEQ asserts `branch`, JR asserts `is_jr` with `op_type` = 1.
- Assert `rst` during BUSY: next cycle `start`, `retire`, `dst_en` all 0, `in_ready` = 1; registers reinitialised.
